// File: rtl/bot_hs_pkg.sv
// Shared constants and the round-robin search used by the bot update/ack handshake block.
package bot_hs_pkg;

    localparam int SNAP_HOLD      = 0;
    localparam int SNAP_OVERWRITE = 1;

    // Field offsets inside one bot-info word; every field is FIELD_W bits wide.
    localparam int FIELD_W = 8;
    localparam int LOCX    = 24;
    localparam int LOCY    = 16;
    localparam int SENS    = 8;
    localparam int INFO    = 0;

    // First set bit of req[n-1:0], searching upward from ptr and wrapping at n-1.
    function automatic logic [2:0] rr_first(input logic [7:0] req,
                                            input logic [2:0] ptr,
                                            input int         n);
        logic [2:0] sel;
        logic       found;
        int         idx;
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i < n) begin
                idx = int'(ptr) + i;
                if (idx >= n) idx = idx - n;
                if (!found && req[idx[2:0]]) begin
                    found = 1'b1;
                    sel   = idx[2:0];
                end
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/bot_update_hs_v2_if.sv
// Bundle of rojobot-side inputs and CPU-side outputs of the update/ack handshake block.
interface bot_update_hs_v2_if #(
    parameter int N_CH  = 2,
    parameter int DW    = 32,
    parameter int OVR_W = 8
);
    localparam int IDW = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [N_CH-1:0]       upd_sysregs;
    logic [N_CH*DW-1:0]    bot_info_in;
    logic [N_CH-1:0]       int_ack;
    logic [N_CH-1:0]       irq_en;
    logic                  ovr_clr;
    logic [N_CH-1:0]       upd_pending;
    logic [N_CH*DW-1:0]    bot_info_snap;
    logic [N_CH*OVR_W-1:0] ovr_cnt;
    logic                  irq;
    logic                  grant_valid;
    logic [IDW-1:0]        grant_id;

    modport master (
        output upd_sysregs, bot_info_in, int_ack, irq_en, ovr_clr,
        input  upd_pending, bot_info_snap, ovr_cnt, irq, grant_valid, grant_id
    );

    modport slave (
        input  upd_sysregs, bot_info_in, int_ack, irq_en, ovr_clr,
        output upd_pending, bot_info_snap, ovr_cnt, irq, grant_valid, grant_id
    );

endinterface

// File: rtl/bot_hs_chan.sv
// One bot channel: update-strobe edge detect, sticky pending flag, info snapshot and
// saturating overrun counter.
module bot_hs_chan
    import bot_hs_pkg::*;
#(
    parameter int DW        = 32,
    parameter int OVR_W     = 8,
    parameter int SNAP_MODE = SNAP_HOLD
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             upd_i,
    input  logic [DW-1:0]    info_i,
    input  logic             ack_i,
    input  logic             ovr_clr_i,
    output logic             pending_o,
    output logic [DW-1:0]    snap_o,
    output logic [OVR_W-1:0] ovr_o
);

    logic             upd_q;
    logic             pending_q, pending_d;
    logic [DW-1:0]    snap_q, snap_d;
    logic [OVR_W-1:0] ovr_q, ovr_d;
    logic             rise;

    assign rise = upd_i & ~upd_q;

    always_comb begin
        // NOTE: every variable gets its hold value first so no path can infer a latch.
        pending_d = pending_q;
        snap_d    = snap_q;
        ovr_d     = ovr_q;
        if (rise) begin
            pending_d = 1'b1;
            if (!pending_q || ack_i || SNAP_MODE == SNAP_OVERWRITE) begin
                snap_d = info_i;
            end
            if (pending_q && !ack_i && ovr_q != '1) begin
                ovr_d = ovr_q + OVR_W'(1);
            end
        end else if (ack_i) begin
            pending_d = 1'b0;
        end
        if (ovr_clr_i) begin
            ovr_d = '0;
        end
    end

    // The strobe history tracks the input even in reset, so a strobe already high
    // when reset releases is seen as a level, not as a fresh edge.
    always_ff @(posedge clk) begin
        upd_q <= upd_i;
    end

    // NOTE: state uses non-blocking assignment; the snapshot register is cleared
    // like any other flop because software may read it straight after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= 1'b0;
            snap_q    <= '0;
            ovr_q     <= '0;
        end else begin
            pending_q <= pending_d;
            snap_q    <= snap_d;
            ovr_q     <= ovr_d;
        end
    end

    assign pending_o = pending_q;
    assign snap_o    = snap_q;
    assign ovr_o     = ovr_q;

endmodule

// File: rtl/bot_update_hs_v2.sv
// N_CH-channel rojobot update/ack handshake with a round-robin arbiter that hands the
// MIPSfpga I/O block one granted channel and a masked interrupt.
module bot_update_hs_v2
    import bot_hs_pkg::*;
#(
    parameter int N_CH      = 2,
    parameter int DW        = 32,
    parameter int OVR_W     = 8,
    parameter int SNAP_MODE = SNAP_HOLD
) (
    input  logic              clk,
    input  logic              reset,
    bot_update_hs_v2_if.slave bus
);

    localparam int IDW = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [N_CH-1:0]       pending;
    logic [N_CH-1:0]       req;
    logic [N_CH*DW-1:0]    snap;
    logic [N_CH*OVR_W-1:0] ovr;
    logic [IDW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]        grant_id;
    logic                  grant_valid;

    for (genvar k = 0; k < N_CH; k++) begin : g_chan
        bot_hs_chan #(
            .DW        (DW),
            .OVR_W     (OVR_W),
            .SNAP_MODE (SNAP_MODE)
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .upd_i     (bus.upd_sysregs[k]),
            .info_i    (bus.bot_info_in[k*DW +: DW]),
            .ack_i     (bus.int_ack[k]),
            .ovr_clr_i (bus.ovr_clr),
            .pending_o (pending[k]),
            .snap_o    (snap[k*DW +: DW]),
            .ovr_o     (ovr[k*OVR_W +: OVR_W])
        );
    end

    // The pointer only moves past a channel once that granted channel is acknowledged.
    always_comb begin
        req         = pending & bus.irq_en;
        grant_valid = |req;
        grant_id    = IDW'(rr_first(8'(req), 3'(rr_ptr_q), N_CH));
        rr_ptr_d    = rr_ptr_q;
        if (grant_valid && bus.int_ack[grant_id]) begin
            rr_ptr_d = (grant_id == IDW'(N_CH - 1)) ? '0 : grant_id + IDW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign bus.upd_pending   = pending;
    assign bus.bot_info_snap = snap;
    assign bus.ovr_cnt       = ovr;
    assign bus.irq           = grant_valid;
    assign bus.grant_valid   = grant_valid;
    assign bus.grant_id      = grant_id;

endmodule

// File: tb/tb_bot_update_hs_v2.sv
// Scoreboard bench for bot_update_hs_v2: three configurations (hold, overwrite with
// 2-bit counters, four channels) driven from one initial block.
module tb_bot_update_hs_v2;

    typedef struct packed {
        logic [3:0]   pend;
        logic [127:0] snap;
        logic [31:0]  ovr;
        logic         irq;
        logic         gv;
        logic [1:0]   gid;
    } obs_t;

    typedef struct {
        string name;
        obs_t  v;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_mis = 0;
    exp_t exp_q[$];
    obs_t obs_q[$];

    always #5 clk = ~clk;

    bot_update_hs_v2_if #(.N_CH(2), .DW(32), .OVR_W(8)) ifa ();
    bot_update_hs_v2_if #(.N_CH(2), .DW(32), .OVR_W(2)) ifb ();
    bot_update_hs_v2_if #(.N_CH(4), .DW(32), .OVR_W(8)) ifc ();

    bot_update_hs_v2 #(.N_CH(2), .DW(32), .OVR_W(8), .SNAP_MODE(0)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa));
    bot_update_hs_v2 #(.N_CH(2), .DW(32), .OVR_W(2), .SNAP_MODE(1)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb));
    bot_update_hs_v2 #(.N_CH(4), .DW(32), .OVR_W(8), .SNAP_MODE(0)) dut_c (
        .clk(clk), .reset(reset), .bus(ifc));

    function automatic obs_t mk(input logic [3:0] pend, input logic [127:0] snap,
                                input logic [31:0] ovr, input logic irq,
                                input logic gv, input logic [1:0] gid);
        obs_t o;
        o.pend = pend; o.snap = snap; o.ovr = ovr;
        o.irq  = irq;  o.gv   = gv;   o.gid = gid;
        return o;
    endfunction

    function automatic obs_t sample(input int d);
        obs_t o;
        case (d)
            0: o = mk(4'(ifa.upd_pending), 128'(ifa.bot_info_snap), 32'(ifa.ovr_cnt),
                      ifa.irq, ifa.grant_valid, 2'(ifa.grant_id));
            1: o = mk(4'(ifb.upd_pending), 128'(ifb.bot_info_snap), 32'(ifb.ovr_cnt),
                      ifb.irq, ifb.grant_valid, 2'(ifb.grant_id));
            default: o = mk(ifc.upd_pending, ifc.bot_info_snap, ifc.ovr_cnt,
                            ifc.irq, ifc.grant_valid, ifc.grant_id);
        endcase
        return o;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("pend=%h snap=%h ovr=%h irq=%b gv=%b gid=%0d",
                         o.pend, o.snap, o.ovr, o.irq, o.gv, o.gid);
    endfunction

    task automatic drive(input int d, input logic [3:0] upd, input logic [3:0] ack,
                         input logic [3:0] en, input logic clr, input logic [127:0] info);
        case (d)
            0: begin
                ifa.upd_sysregs = upd[1:0]; ifa.int_ack = ack[1:0]; ifa.irq_en = en[1:0];
                ifa.ovr_clr = clr; ifa.bot_info_in = info[63:0];
            end
            1: begin
                ifb.upd_sysregs = upd[1:0]; ifb.int_ack = ack[1:0]; ifb.irq_en = en[1:0];
                ifb.ovr_clr = clr; ifb.bot_info_in = info[63:0];
            end
            default: begin
                ifc.upd_sysregs = upd; ifc.int_ack = ack; ifc.irq_en = en;
                ifc.ovr_clr = clr; ifc.bot_info_in = info;
            end
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_obs(input string name, input obs_t v);
        exp_q.push_back('{name, v});
    endtask

    task automatic observe(input int d);
        obs_q.push_back(sample(d));
    endtask

    task automatic test_reset();
        exp_t e;
        obs_t o;
        drive(0, 4'b0001, 4'b0000, 4'b0001, 1'b0, '0);
        drive(1, 4'b0000, 4'b0000, 4'b0001, 1'b0, '0);
        drive(2, 4'b0000, 4'b0000, 4'b1111, 1'b0, '0);
        reset = 1'b1;
        expect_obs("reset_a", mk(0, 0, 0, 0, 0, 0));
        tick(); observe(0);
        expect_obs("reset_c", mk(0, 0, 0, 0, 0, 0));
        observe(2);
        reset = 1'b0;
        expect_obs("held_through_reset", mk(0, 0, 0, 0, 0, 0));
        tick(); observe(0);
        drive(0, 4'b0000, 4'b0000, 4'b0001, 1'b0, '0);
        tick();
        drive(0, 4'b0001, 4'b0000, 4'b0001, 1'b0, 128'h1234_5678);
        expect_obs("first_rise", mk(4'b0001, 128'h1234_5678, 0, 1, 1, 0));
        tick(); observe(0);
        drive(0, 4'b0001, 4'b0001, 4'b0001, 1'b0, 128'h1234_5678);
        expect_obs("first_ack", mk(4'b0000, 128'h1234_5678, 0, 0, 0, 0));
        tick(); observe(0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e.v) begin
                n_mis++;
                $display("FAIL %s: got %s | want %s", e.name, fmt(o), fmt(e.v));
            end
        end
    endtask

    task automatic test_snap_mode(input int d, input logic [31:0] snap2);
        exp_t e;
        obs_t o;
        drive(d, 4'b0000, 4'b0000, 4'b0001, 1'b0, 128'hA);
        tick();
        drive(d, 4'b0001, 4'b0000, 4'b0001, 1'b0, 128'hA);
        expect_obs($sformatf("snap%0d_first", d), mk(4'b0001, 128'hA, 0, 1, 1, 0));
        tick(); observe(d);
        drive(d, 4'b0000, 4'b0000, 4'b0001, 1'b0, 128'hA);
        tick();
        drive(d, 4'b0001, 4'b0000, 4'b0001, 1'b0, 128'hB);
        expect_obs($sformatf("snap%0d_second", d), mk(4'b0001, 128'(snap2), 1, 1, 1, 0));
        tick(); observe(d);
        drive(d, 4'b0000, 4'b0001, 4'b0001, 1'b0, 128'hB);
        expect_obs($sformatf("snap%0d_ack", d), mk(4'b0000, 128'(snap2), 1, 0, 0, 0));
        tick(); observe(d);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e.v) begin
                n_mis++;
                $display("FAIL %s: got %s | want %s", e.name, fmt(o), fmt(e.v));
            end
        end
    endtask

    task automatic test_rise_with_ack();
        exp_t e;
        obs_t o;
        drive(0, 4'b0001, 4'b0000, 4'b0001, 1'b0, 128'hC0C0_C0C0);
        expect_obs("pend_again", mk(4'b0001, 128'hC0C0_C0C0, 1, 1, 1, 0));
        tick(); observe(0);
        drive(0, 4'b0000, 4'b0000, 4'b0001, 1'b0, 128'hC0C0_C0C0);
        tick();
        drive(0, 4'b0001, 4'b0001, 4'b0001, 1'b0, 128'hD00D_D00D);
        expect_obs("rise_and_ack", mk(4'b0001, 128'hD00D_D00D, 1, 1, 1, 0));
        tick(); observe(0);
        drive(0, 4'b0000, 4'b0001, 4'b0001, 1'b0, 128'hD00D_D00D);
        expect_obs("ack_after", mk(4'b0000, 128'hD00D_D00D, 1, 0, 0, 0));
        tick(); observe(0);
        drive(0, 4'b0000, 4'b0001, 4'b0001, 1'b0, 128'hD00D_D00D);
        expect_obs("ack_idle", mk(4'b0000, 128'hD00D_D00D, 1, 0, 0, 0));
        tick(); observe(0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e.v) begin
                n_mis++;
                $display("FAIL %s: got %s | want %s", e.name, fmt(o), fmt(e.v));
            end
        end
    endtask

    task automatic test_saturate();
        exp_t e;
        obs_t o;
        drive(1, 4'b0000, 4'b0000, 4'b0001, 1'b1, 128'hB);
        expect_obs("ovr_clr", mk(4'b0000, 128'hB, 0, 0, 0, 0));
        tick(); observe(1);
        drive(1, 4'b0001, 4'b0000, 4'b0001, 1'b0, 128'h100);
        expect_obs("sat_pend", mk(4'b0001, 128'h100, 0, 1, 1, 0));
        tick(); observe(1);
        for (int i = 1; i <= 5; i++) begin
            drive(1, 4'b0000, 4'b0000, 4'b0001, 1'b0, 128'h100);
            tick();
            drive(1, 4'b0001, 4'b0000, 4'b0001, 1'b0, 128'(32'h100 + i));
            expect_obs($sformatf("sat_rise%0d", i),
                       mk(4'b0001, 128'(32'h100 + i), (i < 3) ? 32'(i) : 32'd3, 1, 1, 0));
            tick(); observe(1);
        end
        drive(1, 4'b0000, 4'b0000, 4'b0001, 1'b0, 128'h105);
        tick();
        drive(1, 4'b0001, 4'b0000, 4'b0001, 1'b1, 128'h106);
        expect_obs("clr_beats_inc", mk(4'b0001, 128'h106, 0, 1, 1, 0));
        tick(); observe(1);
        drive(1, 4'b0000, 4'b0001, 4'b0001, 1'b0, 128'h106);
        expect_obs("sat_ack", mk(4'b0000, 128'h106, 0, 0, 0, 0));
        tick(); observe(1);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e.v) begin
                n_mis++;
                $display("FAIL %s: got %s | want %s", e.name, fmt(o), fmt(e.v));
            end
        end
    endtask

    task automatic test_arbiter();
        exp_t e;
        obs_t o;
        logic [127:0] info, s13;
        info = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        s13  = {32'h4444_4444, 32'h0, 32'h2222_2222, 32'h0};
        drive(2, 4'b1010, 4'b0000, 4'b1111, 1'b0, info);
        expect_obs("arb_first", mk(4'b1010, s13, 0, 1, 1, 1));
        tick(); observe(2);
        drive(2, 4'b0000, 4'b0010, 4'b1111, 1'b0, info);
        expect_obs("arb_ack1", mk(4'b1000, s13, 0, 1, 1, 3));
        tick(); observe(2);
        drive(2, 4'b0010, 4'b1000, 4'b1111, 1'b0, info);
        expect_obs("arb_ack3_reraise1", mk(4'b0010, s13, 0, 1, 1, 1));
        tick(); observe(2);
        drive(2, 4'b0111, 4'b0000, 4'b1111, 1'b0, info);
        expect_obs("arb_wrapped_ptr", mk(4'b0111, info, 0, 1, 1, 0));
        tick(); observe(2);
        drive(2, 4'b0111, 4'b0100, 4'b1111, 1'b0, info);
        expect_obs("arb_ack_nongrant", mk(4'b0011, info, 0, 1, 1, 0));
        tick(); observe(2);
        drive(2, 4'b0111, 4'b0001, 4'b1111, 1'b0, info);
        expect_obs("arb_ack0", mk(4'b0010, info, 0, 1, 1, 1));
        tick(); observe(2);
        drive(2, 4'b0111, 4'b0010, 4'b1111, 1'b0, info);
        expect_obs("arb_empty", mk(4'b0000, info, 0, 0, 0, 0));
        tick(); observe(2);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e.v) begin
                n_mis++;
                $display("FAIL %s: got %s | want %s", e.name, fmt(o), fmt(e.v));
            end
        end
    endtask

    task automatic test_mask_and_reset();
        exp_t e;
        obs_t o;
        drive(0, 4'b0001, 4'b0000, 4'b0000, 1'b0, 128'hEEEE_0001);
        expect_obs("masked_pend", mk(4'b0001, 128'hEEEE_0001, 1, 0, 0, 0));
        tick(); observe(0);
        drive(0, 4'b0011, 4'b0000, 4'b0000, 1'b0, {64'h0, 32'hF00F_0002, 32'hEEEE_0001});
        expect_obs("masked_both", mk(4'b0011, {64'h0, 32'hF00F_0002, 32'hEEEE_0001}, 1, 0, 0, 0));
        tick(); observe(0);
        drive(0, 4'b0011, 4'b0000, 4'b0010, 1'b0, {64'h0, 32'hF00F_0002, 32'hEEEE_0001});
        #1;
        expect_obs("enable_same_cycle", mk(4'b0011, {64'h0, 32'hF00F_0002, 32'hEEEE_0001}, 1, 1, 1, 1));
        observe(0);
        reset = 1'b1;
        expect_obs("mid_reset_a", mk(0, 0, 0, 0, 0, 0));
        tick(); observe(0);
        expect_obs("mid_reset_c", mk(0, 0, 0, 0, 0, 0));
        observe(2);
        reset = 1'b0;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e.v) begin
                n_mis++;
                $display("FAIL %s: got %s | want %s", e.name, fmt(o), fmt(e.v));
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_snap_mode(0, 32'hA);
        test_snap_mode(1, 32'hB);
        test_rise_with_ack();
        test_saturate();
        test_arbiter();
        test_mask_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
